// File: rtl/vic_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package vic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } vic_state_e;

    localparam int unsigned CFG_W    = 4;
    localparam int unsigned CFG_EN   = 3;
    localparam int unsigned CFG_RISE = 2;
    localparam int unsigned CFG_FALL = 1;
    localparam int unsigned CFG_LVL  = 0;

    localparam int unsigned VIC_N_IRQ_DEF  = 31;
    localparam int unsigned VIC_PRIO_W_DEF = 3;

    // Vector address width, never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vic_irq_ctrl_if.sv
// CPU-side request/acknowledge handshake of the interrupt controller.
interface vic_irq_ctrl_if
    import vic_pkg::*;
#(
    parameter int unsigned ADDR_W = addr_width(VIC_N_IRQ_DEF)
);
    logic              i_ack;
    logic              i_eoi;
    logic              o_irq;
    logic [ADDR_W-1:0] o_irq_addr;
    logic              o_pending;
    logic              o_busy;

    modport master (
        output i_ack, i_eoi,
        input  o_irq, o_irq_addr, o_pending, o_busy
    );

    modport slave (
        input  i_ack, i_eoi,
        output o_irq, o_irq_addr, o_pending, o_busy
    );
endinterface

// File: rtl/vic_prio_arb.sv
// Combinational priority arbiter: highest priority wins, ties go to the lowest index.
module vic_prio_arb
    import vic_pkg::*;
#(
    parameter int unsigned N_IRQ  = VIC_N_IRQ_DEF,
    parameter int unsigned PRIO_W = VIC_PRIO_W_DEF
) (
    input  logic [N_IRQ-1:0]             i_req,
    input  logic [N_IRQ*PRIO_W-1:0]      i_prio,
    output logic [addr_width(N_IRQ)-1:0] o_win_c,
    output logic                         o_valid_c
);
    localparam int unsigned IDX_W = addr_width(N_IRQ);

    logic [PRIO_W-1:0] w_best;

    // Strict '>' keeps the earlier (lower) index on equal priority.
    always_comb begin
        o_win_c   = '0;
        o_valid_c = 1'b0;
        w_best    = '0;
        for (int i = 0; i < int'(N_IRQ); i++) begin
            if (i_req[i] && (!o_valid_c || (i_prio[PRIO_W*i +: PRIO_W] > w_best))) begin
                o_valid_c = 1'b1;
                w_best    = i_prio[PRIO_W*i +: PRIO_W];
                o_win_c   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/vic_irq_ctrl.sv
// Vectored interrupt controller: source synchronisation, edge/level pending, arbitration, CPU handshake FSM.
module vic_irq_ctrl
    import vic_pkg::*;
#(
    parameter int unsigned N_IRQ  = VIC_N_IRQ_DEF,
    parameter int unsigned PRIO_W = VIC_PRIO_W_DEF,
    parameter int unsigned ADDR_W = addr_width(N_IRQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_IRQ-1:0]        i_ext,
    input  logic [CFG_W*N_IRQ-1:0]  i_cfg,
    input  logic [N_IRQ*PRIO_W-1:0] i_prio,
    input  logic                    i_en,
    vic_irq_ctrl_if.slave           cpu
);
    localparam int unsigned IDX_W = addr_width(N_IRQ);

    logic [N_IRQ-1:0]  r_sync1, r_sync2, r_dly, r_pend;
    logic [N_IRQ-1:0]  w_pend_n, w_req, w_rise_ev, w_fall_ev;
    logic [IDX_W-1:0]  w_win;
    logic              w_valid;
    logic              w_ack_take;
    vic_state_e        r_state, w_state_n;
    logic              r_irq, w_irq_n;
    logic              r_busy, w_busy_n;
    logic              r_pending;
    logic [ADDR_W-1:0] r_addr, w_addr_n;

    assign w_rise_ev = r_sync2 & ~r_dly;
    assign w_fall_ev = ~r_sync2 & r_dly;

    // Per-source pending update; a new edge wins over the acknowledge clear.
    always_comb begin
        w_pend_n = r_pend;
        w_req    = '0;
        for (int i = 0; i < int'(N_IRQ); i++) begin
            w_req[i] = r_pend[i] & i_cfg[CFG_W*i + CFG_EN];
            if (!i_cfg[CFG_W*i + CFG_EN]) begin
                w_pend_n[i] = 1'b0;
            end else if (!i_cfg[CFG_W*i + CFG_RISE] && !i_cfg[CFG_W*i + CFG_FALL]) begin
                w_pend_n[i] = (r_sync2[i] == i_cfg[CFG_W*i + CFG_LVL]);
            end else begin
                w_pend_n[i] = (i_cfg[CFG_W*i + CFG_RISE] & w_rise_ev[i])
                            | (i_cfg[CFG_W*i + CFG_FALL] & w_fall_ev[i])
                            | (r_pend[i] & ~(w_ack_take && (ADDR_W'(i) == r_addr)));
            end
        end
    end

    vic_prio_arb #(
        .N_IRQ  (N_IRQ),
        .PRIO_W (PRIO_W)
    ) u_arb (
        .i_req     (w_req),
        .i_prio    (i_prio),
        .o_win_c   (w_win),
        .o_valid_c (w_valid)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_n  = r_state;
        w_irq_n    = r_irq;
        w_busy_n   = r_busy;
        w_addr_n   = r_addr;
        w_ack_take = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_en && w_valid) begin
                    w_addr_n  = ADDR_W'(w_win);
                    w_irq_n   = 1'b1;
                    w_state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                if (cpu.i_ack) begin
                    w_ack_take = 1'b1;
                    w_irq_n    = 1'b0;
                    w_busy_n   = 1'b1;
                    w_state_n  = ST_SERVICE;
                end else if (!i_en || !w_valid) begin
                    w_irq_n   = 1'b0;
                    w_state_n = ST_IDLE;
                end else begin
                    w_addr_n = ADDR_W'(w_win);
                end
            end
            ST_SERVICE: begin
                if (cpu.i_eoi) begin
                    w_busy_n  = 1'b0;
                    w_state_n = ST_IDLE;
                end
            end
            default: begin
                w_irq_n   = 1'b0;
                w_busy_n  = 1'b0;
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_dly     <= '0;
            r_pend    <= '0;
            r_state   <= ST_IDLE;
            r_irq     <= 1'b0;
            r_busy    <= 1'b0;
            r_addr    <= '0;
            r_pending <= 1'b0;
        end else begin
            r_sync1   <= i_ext;
            r_sync2   <= r_sync1;
            r_dly     <= r_sync2;
            r_pend    <= w_pend_n;
            r_state   <= w_state_n;
            r_irq     <= w_irq_n;
            r_busy    <= w_busy_n;
            r_addr    <= w_addr_n;
            r_pending <= |(w_pend_n & ~(N_IRQ'(1) << w_addr_n));
        end
    end

    assign cpu.o_irq      = r_irq;
    assign cpu.o_irq_addr = r_addr;
    assign cpu.o_pending  = r_pending;
    assign cpu.o_busy     = r_busy;

endmodule

// File: tb/tb_vic_irq_ctrl.sv
// Directed bench for vic_irq_ctrl: cycle table for edge/priority flows, hand sequences for level, reset and enable cases.
module tb_vic_irq_ctrl;
    import vic_pkg::*;

    localparam int unsigned N  = 31;
    localparam int unsigned PW = 3;
    localparam int unsigned AW = 5;
    localparam int unsigned NV = 27;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    ext;
    logic [4*N-1:0]  cfg;
    logic [N*PW-1:0] prio;
    logic            en;

    vic_irq_ctrl_if #(.ADDR_W(AW)) cpu ();

    vic_irq_ctrl #(
        .N_IRQ  (N),
        .PRIO_W (PW),
        .ADDR_W (AW)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_ext  (ext),
        .i_cfg  (cfg),
        .i_prio (prio),
        .i_en   (en),
        .cpu    (cpu)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  ext;
        logic          ack;
        logic          eoi;
        logic          irq;
        logic [AW-1:0] addr;
        logic          pending;
        logic          busy;
    } vec_t;

    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [N-1:0] bitn(input int k);
        return N'(1) << k;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] e, input int a, input int o,
                                input int irq, input int addr, input int p, input int b);
        vec_t v;
        v.ext     = e;
        v.ack     = 1'(a);
        v.eoi     = 1'(o);
        v.irq     = 1'(irq);
        v.addr    = AW'(addr);
        v.pending = 1'(p);
        v.busy    = 1'(b);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int irq, input int addr,
                              input int pend, input int busy);
        chk({tag, ".irq"},     int'(cpu.o_irq),      irq);
        chk({tag, ".addr"},    int'(cpu.o_irq_addr), addr);
        chk({tag, ".pending"}, int'(cpu.o_pending),  pend);
        chk({tag, ".busy"},    int'(cpu.o_busy),     busy);
    endtask

    task automatic set_src(input int i, input logic [3:0] c, input int p);
        cfg[4*i +: 4]   = c;
        prio[PW*i +: PW] = PW'(p);
    endtask

    task automatic pulse_ack();
        cpu.i_ack = 1'b1;
        tick();
        cpu.i_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        cpu.i_eoi = 1'b1;
        tick();
        cpu.i_eoi = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst       = 1'b1;
        ext       = '0;
        cfg       = '0;
        prio      = '0;
        en        = 1'b1;
        cpu.i_ack = 1'b0;
        cpu.i_eoi = 1'b0;
        set_src(5, 4'b1100, 2);
        set_src(3, 4'b1100, 1);
        set_src(9, 4'b1100, 6);
        set_src(2, 4'b1100, 4);
        set_src(7, 4'b1100, 4);
        set_src(4, 4'b1001, 5);
        set_src(1, 4'b1100, 0);
        set_src(6, 4'b1100, 3);

        // ext, ack, eoi -> irq, addr, pending, busy after the next rising edge
        vecs[0]  = mk(bitn(5),            0, 0, 0, 0, 0, 0);
        vecs[1]  = mk('0,                 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk('0,                 0, 0, 0, 0, 1, 0);
        vecs[3]  = mk('0,                 0, 0, 1, 5, 0, 0);
        vecs[4]  = mk('0,                 1, 0, 0, 5, 0, 1);
        vecs[5]  = mk('0,                 0, 0, 0, 5, 0, 1);
        vecs[6]  = mk('0,                 0, 1, 0, 5, 0, 0);
        vecs[7]  = mk('0,                 0, 0, 0, 5, 0, 0);
        vecs[8]  = mk(bitn(3) | bitn(9),  0, 0, 0, 5, 0, 0);
        vecs[9]  = mk('0,                 0, 0, 0, 5, 0, 0);
        vecs[10] = mk('0,                 0, 0, 0, 5, 1, 0);
        vecs[11] = mk('0,                 0, 0, 1, 9, 1, 0);
        vecs[12] = mk('0,                 1, 0, 0, 9, 1, 1);
        vecs[13] = mk('0,                 0, 0, 0, 9, 1, 1);
        vecs[14] = mk('0,                 0, 1, 0, 9, 1, 0);
        vecs[15] = mk('0,                 0, 0, 1, 3, 0, 0);
        vecs[16] = mk('0,                 1, 0, 0, 3, 0, 1);
        vecs[17] = mk('0,                 0, 1, 0, 3, 0, 0);
        vecs[18] = mk(bitn(2) | bitn(7),  0, 0, 0, 3, 0, 0);
        vecs[19] = mk('0,                 0, 0, 0, 3, 0, 0);
        vecs[20] = mk('0,                 0, 0, 0, 3, 1, 0);
        vecs[21] = mk('0,                 0, 0, 1, 2, 1, 0);
        vecs[22] = mk('0,                 1, 0, 0, 2, 1, 1);
        vecs[23] = mk('0,                 0, 1, 0, 2, 1, 0);
        vecs[24] = mk('0,                 0, 0, 1, 7, 0, 0);
        vecs[25] = mk('0,                 1, 0, 0, 7, 0, 1);
        vecs[26] = mk('0,                 0, 1, 0, 7, 0, 0);

        tick();
        tick();
        check_outs("reset", 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        check_outs("reset_release", 0, 0, 0, 0);

        for (int i = 0; i < int'(NV); i++) begin
            ext       = vecs[i].ext;
            cpu.i_ack = vecs[i].ack;
            cpu.i_eoi = vecs[i].eoi;
            tick();
            check_outs($sformatf("vec%0d", i), int'(vecs[i].irq), int'(vecs[i].addr),
                       int'(vecs[i].pending), int'(vecs[i].busy));
        end
        ext       = '0;
        cpu.i_ack = 1'b0;
        cpu.i_eoi = 1'b0;

        // Level source 4 held active: request, service, re-request, then removal.
        ext = bitn(4);
        repeat (3) tick();
        chk("lvl.pre_irq", int'(cpu.o_irq), 0);
        tick();
        chk("lvl.irq", int'(cpu.o_irq), 1);
        chk("lvl.addr", int'(cpu.o_irq_addr), 4);
        pulse_ack();
        chk("lvl.ack_irq", int'(cpu.o_irq), 0);
        chk("lvl.ack_busy", int'(cpu.o_busy), 1);
        pulse_eoi();
        chk("lvl.eoi_busy", int'(cpu.o_busy), 0);
        chk("lvl.eoi_irq", int'(cpu.o_irq), 0);
        tick();
        chk("lvl.rereq_irq", int'(cpu.o_irq), 1);
        chk("lvl.rereq_addr", int'(cpu.o_irq_addr), 4);
        ext = '0;
        k = 0;
        while (cpu.o_irq && k < 4) begin
            tick();
            k++;
        end
        chk("lvl.drop_irq", int'(cpu.o_irq), 0);
        tick();
        chk("lvl.idle_irq", int'(cpu.o_irq), 0);
        chk("lvl.idle_busy", int'(cpu.o_busy), 0);

        // Source held high through reset yields a rising edge after release.
        ext = bitn(5);
        rst = 1'b1;
        tick();
        tick();
        check_outs("rst_hold.in_reset", 0, 0, 0, 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_hold.pre_irq", int'(cpu.o_irq), 0);
        tick();
        chk("rst_hold.irq", int'(cpu.o_irq), 1);
        chk("rst_hold.addr", int'(cpu.o_irq_addr), 5);
        pulse_ack();
        pulse_eoi();
        ext = '0;
        repeat (3) tick();
        chk("rst_hold.clean_irq", int'(cpu.o_irq), 0);

        // Reset while a request is outstanding abandons it.
        ext = bitn(1);
        tick();
        ext = '0;
        repeat (3) tick();
        chk("rst_mid.irq", int'(cpu.o_irq), 1);
        chk("rst_mid.addr", int'(cpu.o_irq_addr), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outs("rst_mid.after", 0, 0, 0, 0);
        repeat (6) tick();
        check_outs("rst_mid.quiet", 0, 0, 0, 0);

        // Global enable dropped during REQ withdraws the request; pend survives.
        ext = bitn(1);
        tick();
        ext = '0;
        repeat (3) tick();
        chk("en_fall.irq", int'(cpu.o_irq), 1);
        en = 1'b0;
        tick();
        chk("en_fall.drop_irq", int'(cpu.o_irq), 0);
        chk("en_fall.busy", int'(cpu.o_busy), 0);
        en = 1'b1;
        tick();
        chk("en_fall.resume_irq", int'(cpu.o_irq), 1);
        chk("en_fall.resume_addr", int'(cpu.o_irq_addr), 1);
        pulse_ack();
        pulse_eoi();

        // Edge latched while globally disabled is delivered once enabled.
        en  = 1'b0;
        ext = bitn(6);
        tick();
        ext = '0;
        repeat (5) tick();
        chk("en_off.irq", int'(cpu.o_irq), 0);
        chk("en_off.pending", int'(cpu.o_pending), 1);
        en = 1'b1;
        tick();
        chk("en_on.irq", int'(cpu.o_irq), 1);
        chk("en_on.addr", int'(cpu.o_irq_addr), 6);
        pulse_ack();
        chk("en_on.ack_busy", int'(cpu.o_busy), 1);
        pulse_eoi();
        check_outs("final", 0, 6, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
